// File: rtl/op_decoder_pkg.sv
// Shared opcode, ALU-op and control-bundle encodings for the decode stage.
// The OP_DECODER_ILLEGAL_TRAP_EN build makes ST_TRAP reachable.
package op_decoder_pkg;

    localparam int CTRL_W = 10;

    // Control bundle bit positions, MSB first
    localparam int CB_BRANCH   = 9;
    localparam int CB_J1       = 8;
    localparam int CB_J2       = 7;
    localparam int CB_WEDM     = 6;
    localparam int CB_WEREG    = 5;
    localparam int CB_WEREGDM  = 4;
    localparam int CB_ALUOP    = 3;
    localparam int CB_IMM      = 2;
    localparam int CB_WESTATUS = 1;
    localparam int CB_WERETURN = 0;

    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] OPC_J     = 5'b00001;
    localparam logic [4:0] OPC_BNE   = 5'b00010;
    localparam logic [4:0] OPC_JAL   = 5'b00011;
    localparam logic [4:0] OPC_JR    = 5'b00100;
    localparam logic [4:0] OPC_ADDI  = 5'b00101;
    localparam logic [4:0] OPC_BLT   = 5'b00110;
    localparam logic [4:0] OPC_SW    = 5'b00111;
    localparam logic [4:0] OPC_LW    = 5'b01000;
    localparam logic [4:0] OPC_SETX  = 5'b10101;
    localparam logic [4:0] OPC_BEX   = 5'b10110;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [CTRL_W-1:0] CTRL_RTYPE = 10'b0000101010;
    localparam logic [CTRL_W-1:0] CTRL_J     = 10'b0100000000;
    localparam logic [CTRL_W-1:0] CTRL_BNE   = 10'b1000000000;
    localparam logic [CTRL_W-1:0] CTRL_JAL   = 10'b0100000001;
    localparam logic [CTRL_W-1:0] CTRL_JR    = 10'b0010000000;
    localparam logic [CTRL_W-1:0] CTRL_ADDI  = 10'b0000101110;
    localparam logic [CTRL_W-1:0] CTRL_BLT   = 10'b1000000000;
    localparam logic [CTRL_W-1:0] CTRL_SW    = 10'b0001000100;
    localparam logic [CTRL_W-1:0] CTRL_LW    = 10'b0000110100;
    localparam logic [CTRL_W-1:0] CTRL_SETX  = 10'b0000000010;
    localparam logic [CTRL_W-1:0] CTRL_BEX   = 10'b1000000000;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_MD_WAIT = 2'd2,
        ST_TRAP    = 2'd3
    } state_t;

endpackage

// File: rtl/op_decoder_lut.sv
// Combinational opcode/ALU-op decode into the control bundle plus
// mul/div and illegal-opcode flags.
import op_decoder_pkg::*;

module op_decoder_lut #(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [4:0]        alu_op,
    output logic [CTRL_W-1:0] ctrl,
    output logic              is_muldiv,
    output logic              illegal
);

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_W'(OPC_RTYPE): ctrl = CTRL_RTYPE;
            OP_W'(OPC_J):     ctrl = CTRL_J;
            OP_W'(OPC_BNE):   ctrl = CTRL_BNE;
            OP_W'(OPC_JAL):   ctrl = CTRL_JAL;
            OP_W'(OPC_JR):    ctrl = CTRL_JR;
            OP_W'(OPC_ADDI):  ctrl = CTRL_ADDI;
            OP_W'(OPC_BLT):   ctrl = CTRL_BLT;
            OP_W'(OPC_SW):    ctrl = CTRL_SW;
            OP_W'(OPC_LW):    ctrl = CTRL_LW;
            OP_W'(OPC_SETX):  ctrl = CTRL_SETX;
            OP_W'(OPC_BEX):   ctrl = CTRL_BEX;
            default:          illegal = 1'b1;
        endcase
    end

    assign is_muldiv = (opcode == OP_W'(OPC_RTYPE)) &&
                       ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));

endmodule

// File: rtl/op_decoder_stage.sv
// Registered decode stage with valid/ready output slot and mul/div hold.
// Define OP_DECODER_ILLEGAL_TRAP_EN to stall in ST_TRAP after an illegal opcode.
import op_decoder_pkg::*;

module op_decoder_stage #(
    parameter int INSTR_W       = 32,
    parameter int OP_W          = 5,
    parameter int MULDIV_CYCLES = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [INSTR_W-1:0] out_instr,
    output logic               md_start,
    output logic               md_busy,
    output logic               out_illegal
);

    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    logic [CTRL_W-1:0] lut_ctrl;
    logic              lut_md;
    logic              lut_illegal;
    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              accept;
    logic              trap_on_drain;

    op_decoder_lut #(.OP_W(OP_W)) u_lut (
        .opcode    (in_instr[INSTR_W-1 -: OP_W]),
        .alu_op    (in_instr[6:2]),
        .ctrl      (lut_ctrl),
        .is_muldiv (lut_md),
        .illegal   (lut_illegal)
    );

`ifdef OP_DECODER_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign out_illegal   = illegal_q;
    assign trap_on_drain = illegal_q;
    // An illegal instruction must drain alone so the stage lands in ST_TRAP
    assign in_ready = !flush && ((state == ST_EMPTY) ||
                                 ((state == ST_FULL) && out_ready && !illegal_q));
`else
    logic unused_illegal;
    assign unused_illegal = lut_illegal;
    assign out_illegal    = 1'b0;
    assign trap_on_drain  = 1'b0;
    assign in_ready = !flush && ((state == ST_EMPTY) ||
                                 ((state == ST_FULL) && out_ready));
`endif

    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_FULL);
    assign md_busy   = (state == ST_MD_WAIT);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (flush) begin
            state_n = ST_EMPTY;
            cnt_n   = '0;
        end else if (accept) begin
            if (lut_md) begin
                state_n = ST_MD_WAIT;
                cnt_n   = CNT_W'(MULDIV_CYCLES - 1);
            end else begin
                state_n = ST_FULL;
            end
        end else begin
            case (state)
                ST_FULL: if (out_ready) state_n = trap_on_drain ? ST_TRAP : ST_EMPTY;
                ST_MD_WAIT: begin
                    if (cnt == '0) state_n = ST_FULL;
                    else           cnt_n   = cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_EMPTY;
            cnt       <= '0;
            out_ctrl  <= '0;
            out_instr <= '0;
            md_start  <= 1'b0;
`ifdef OP_DECODER_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            md_start <= accept && lut_md;
            // Payload is left stale on flush; only out_valid qualifies it
            if (accept) begin
                out_ctrl  <= lut_ctrl;
                out_instr <= in_instr;
            end
`ifdef OP_DECODER_ILLEGAL_TRAP_EN
            if (flush)       illegal_q <= 1'b0;
            else if (accept) illegal_q <= lut_illegal;
`endif
        end
    end

endmodule
